mic_frame_scheduler: RTL and testbench
======================================

# mic_frame_scheduler

Sequences microphone ADC samples into fixed-length complex frames for the FFT. It decimates the free-running 12-bit ADC output to the audio sample rate and formats each sample as a WIDTH-bit complex word with zero imaginary part. Samples are captured into a ping-pong frame buffer while the other bank streams to the FFT over a valid/ready handshake. It sits between the ADC wrapper and the FFT input.

## Interface
- WIDTH, 32: complex word width; real in [WIDTH/2-1:0], imaginary in [WIDTH-1:WIDTH/2].
- FRAME_LEN, 64: samples per frame; power of two, at least 4.
- DECIM, 16: adc_clk cycles per captured sample; at least 2.
- adc_clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture enable.
- mic_sample  in  12  raw ADC CH0 value, unsigned.
- fft_tdata  out  WIDTH  formatted sample.
- fft_tvalid  out  1  fft_tdata valid.
- fft_tready  in  1  FFT accepts the word.
- fft_tlast  out  1  last word of a frame.
- overrun  out  1  sticky: at least one sample was dropped.
- samples_dropped  out  16  count of discarded samples; saturates at 0xFFFF.
- capturing  out  1  high while a frame is being written.

## Operation
- Decimator: counter 0..DECIM-1, running only while enable=1. A strobe fires when the counter is at DECIM-1. The counter clears whenever enable=0.
- Format without macro: real = {zeros, mic_sample >> 5}, zero-extended to WIDTH/2. Imaginary = 0.
- Capture FSM, states IDLE, WAIT_BANK, FILL:
  - IDLE goes to WAIT_BANK when enable=1.
  - In WAIT_BANK, on a strobe with the target bank EMPTY: write the sample to index 0 and go to FILL.
  - In WAIT_BANK, on a strobe with the target bank busy: discard the sample, set overrun, and increment samples_dropped.
  - In FILL, each strobe writes at wr_idx and increments it. The write at FRAME_LEN-1 marks the bank FULL, toggles the target bank, and returns to WAIT_BANK.
- Bank states are EMPTY, FULL and DRAINING. A bank returns to EMPTY on the handshake of its fft_tlast word.
- Drain FSM, states IDLE and STREAM:
  - Banks drain in fill order, addresses 0..FRAME_LEN-1.
  - A word transfers when fft_tvalid=1 and fft_tready=1.
  - fft_tdata, fft_tvalid and fft_tlast stay stable while fft_tvalid=1 and fft_tready=0.
- enable falls during FILL: the partial frame is discarded, the bank returns to EMPTY, wr_idx returns to 0, and the FSM goes to IDLE. FULL or DRAINING banks finish draining normally.
- capturing = 1 only in FILL.

## Timing
- Reset values:
  - All outputs 0.
  - Both banks EMPTY, target bank 0.
  - Both FSMs IDLE, all counters 0.
- Reset mid-stream aborts everything. Buffered frames are lost.
- First strobe arrives DECIM cycles after enable rises (enable sampled high on cycle 0, strobe on cycle DECIM-1).
- fft_tvalid rises on the cycle after the bank's final write edge.
- With fft_tready held high, a frame streams in exactly FRAME_LEN consecutive cycles.
- Back-to-back frames: the next bank's word 0 is presented on the cycle after the tlast handshake, with no bubble if that bank is FULL.
- Simultaneous events on one edge:
  - If a bank's tlast handshake and a WAIT_BANK strobe targeting that bank coincide, the strobe sees the bank as busy and drops the sample.
  - The bank frees on the following cycle.
- Because DECIM ≥ 2 and drain takes at most FRAME_LEN·DECIM cycles when ready is held high, an always-ready FFT never causes a drop.

## Configuration
- MIC_DC_REMOVE_EN defined: real = sign-extend((mic_sample − 2048) >>> 5) to WIDTH/2, giving a range of −64..63. Imaginary = 0.
- MIC_DC_REMOVE_EN undefined: the zero-extended mic_sample >> 5 format above, range 0..127.

## Structure
- Shared package mic_pkg holds:
  - ADC_W = 12, MIC_SHIFT = 5, MIC_MIDSCALE = 2048.
  - Enum typedefs for cap_state_t, drain_state_t and bank_state_t.
- One sub-module, mic_frame_bank:
  - 2×FRAME_LEN×(WIDTH/2) dual-port RAM storing real parts only; the imaginary half is regenerated as zero on output.
  - Registered read, with write port and read port addressed by {bank, idx}.
- Read latency is hidden in the top level by prefetching the next word.

## Test plan
- DECIM=4, FRAME_LEN=8, ready high, ramp mic_sample=0,32,64,…: fft_tdata low halves 0..7, tlast on the 8th word, upper half 0.
- Hold fft_tready=0 for 40 cycles mid-frame: tdata and tlast stay stable. Once the second bank fills and the next sample is dropped, overrun=1 and samples_dropped increments once per subsequent strobe.
- Drop enable after 3 samples of a frame: no fft_tvalid from that frame. Re-enable: a fresh frame starts at index 0.
- Assert reset during STREAM: on the next cycle all outputs are 0 and the banks are EMPTY.
- With MIC_DC_REMOVE_EN, mic_sample=0: low half = 0xFFC0 (−64). mic_sample=4095: low half = 63.
- Ready held high over 10 frames: tlast handshakes are exactly FRAME_LEN·DECIM cycles apart and overrun stays 0.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared constants and state encodings for the microphone frame scheduler.
package mic_pkg;
  localparam int ADC_W        = 12;
  localparam int MIC_SHIFT    = 5;
  localparam int MIC_MIDSCALE = 2048;

  typedef enum logic [1:0] {CAP_IDLE, CAP_WAIT_BANK, CAP_FILL} cap_state_t;
  typedef enum logic {DRN_IDLE, DRN_STREAM} drain_state_t;
  typedef enum logic [1:0] {BANK_EMPTY, BANK_FULL, BANK_DRAINING} bank_state_t;
endpackage

// File: rtl/mic_frame_scheduler_if.sv
// FFT-side valid/ready stream carrying complex sample words.
interface mic_frame_scheduler_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] fft_tdata;
  logic             fft_tvalid;
  logic             fft_tready;
  logic             fft_tlast;

  modport master (output fft_tdata, output fft_tvalid, output fft_tlast, input fft_tready);
  modport slave  (input fft_tdata, input fft_tvalid, input fft_tlast, output fft_tready);
endinterface

// File: rtl/mic_frame_bank.sv
// Ping-pong frame storage: two banks of real parts, one write port, one registered read port.
module mic_frame_bank #(
  parameter int FRAME_LEN = 64,
  parameter int DATA_W    = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(FRAME_LEN):0] wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(FRAME_LEN):0] rd_addr,
  output logic [DATA_W-1:0]          rd_data
);
  logic [DATA_W-1:0] mem [2*FRAME_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/mic_frame_scheduler.sv
// Decimates ADC samples into ping-pong frames and streams them to the FFT.
// Build option: define MIC_DC_REMOVE_EN to store mid-scale-removed signed samples.
module mic_frame_scheduler
  import mic_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 64,
  parameter int DECIM     = 16
) (
  input  logic                  adc_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADC_W-1:0]      mic_sample,
  mic_frame_scheduler_if.master fft,
  output logic                  overrun,
  output logic [15:0]           samples_dropped,
  output logic                  capturing
);
  localparam int HALF_W = WIDTH / 2;
  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int CNT_W  = $clog2(DECIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  function automatic logic [HALF_W-1:0] fmt_real(input logic [ADC_W-1:0] s);
`ifdef MIC_DC_REMOVE_EN
    logic signed [ADC_W:0] centered;
    centered = $signed({1'b0, s}) - $signed((ADC_W+1)'(MIC_MIDSCALE));
    return HALF_W'(centered >>> MIC_SHIFT);
`else
    return HALF_W'(s >> MIC_SHIFT);
`endif
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [CNT_W-1:0] dec_cnt;
  logic             strobe;
  cap_state_t       cap_state, cap_next;
  drain_state_t     drn_state, drn_next;
  bank_state_t      bank_st [2];
  logic             tgt_bank, rd_bank, claim_bank, rd_bank_sel;
  logic [IDX_W-1:0] wr_idx, rd_idx, rd_idx_sel;
  logic             tgt_empty, wr_en, drop, frame_done;
  logic             cur_full, other_full, hs, load, claim, release_bank;
  logic [HALF_W-1:0] real_p0, rd_real_p1, out_real_p2;
  logic             vld_p2, last_p2;

  assign strobe = enable && (dec_cnt == CNT_W'(DECIM - 1));

  always_ff @(posedge adc_clk) begin
    if (reset || !enable || strobe) dec_cnt <= '0;
    else                            dec_cnt <= dec_cnt + 1'b1;
  end

  // Capture FSM
  assign tgt_empty = (bank_st[tgt_bank] == BANK_EMPTY);

  always_ff @(posedge adc_clk) begin
    if (reset) cap_state <= CAP_IDLE;
    else       cap_state <= cap_next;
  end

  always_comb begin
    cap_next = cap_state;
    case (cap_state)
      CAP_IDLE:      if (enable) cap_next = CAP_WAIT_BANK;
      CAP_WAIT_BANK: if (!enable) cap_next = CAP_IDLE;
                     else if (strobe && tgt_empty) cap_next = CAP_FILL;
      CAP_FILL:      if (!enable) cap_next = CAP_IDLE;
                     else if (strobe && wr_idx == LAST_IDX) cap_next = CAP_WAIT_BANK;
      default:       cap_next = CAP_IDLE;
    endcase
  end

  always_comb begin
    wr_en      = 1'b0;
    drop       = 1'b0;
    frame_done = 1'b0;
    capturing  = (cap_state == CAP_FILL);
    case (cap_state)
      CAP_WAIT_BANK: begin
        wr_en = strobe && tgt_empty;
        drop  = strobe && !tgt_empty;
      end
      CAP_FILL: begin
        wr_en      = strobe;
        frame_done = strobe && (wr_idx == LAST_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      tgt_bank        <= 1'b0;
      wr_idx          <= '0;
      overrun         <= 1'b0;
      samples_dropped <= '0;
    end else begin
      if (cap_state == CAP_FILL && !enable) wr_idx <= '0;
      else if (wr_en)                       wr_idx <= wr_idx + 1'b1;
      if (frame_done) tgt_bank <= ~tgt_bank;
      if (drop) begin
        overrun         <= 1'b1;
        samples_dropped <= sat_inc(samples_dropped);
      end
    end
  end

  // p0: format sample for storage
  assign real_p0 = fmt_real(mic_sample);

  // p1: bank RAM read, address steered one word ahead of the output register
  mic_frame_bank #(.FRAME_LEN(FRAME_LEN), .DATA_W(HALF_W)) u_bank (
    .clk     (adc_clk),
    .wr_en   (wr_en),
    .wr_addr ({tgt_bank, wr_idx}),
    .wr_data (real_p0),
    .rd_addr ({rd_bank_sel, rd_idx_sel}),
    .rd_data (rd_real_p1)
  );

  // Drain FSM
  assign cur_full   = (bank_st[rd_bank] == BANK_FULL);
  assign other_full = (bank_st[~rd_bank] == BANK_FULL);
  assign hs         = vld_p2 && fft.fft_tready;

  always_ff @(posedge adc_clk) begin
    if (reset) drn_state <= DRN_IDLE;
    else       drn_state <= drn_next;
  end

  always_comb begin
    drn_next = drn_state;
    case (drn_state)
      DRN_IDLE:   if (cur_full) drn_next = DRN_STREAM;
      DRN_STREAM: if (hs && last_p2 && !other_full) drn_next = DRN_IDLE;
      default:    drn_next = DRN_IDLE;
    endcase
  end

  // While the last word is on the bus the RAM already reads the other bank's word 0.
  always_comb begin
    load         = 1'b0;
    claim        = 1'b0;
    claim_bank   = rd_bank;
    release_bank = 1'b0;
    rd_bank_sel  = rd_bank;
    rd_idx_sel   = rd_idx;
    case (drn_state)
      DRN_IDLE: begin
        rd_idx_sel = '0;
        if (cur_full) begin
          load       = 1'b1;
          claim      = 1'b1;
          rd_idx_sel = IDX_W'(1);
        end
      end
      DRN_STREAM: begin
        if (last_p2) begin
          rd_bank_sel = ~rd_bank;
          rd_idx_sel  = '0;
          if (hs) begin
            release_bank = 1'b1;
            if (other_full) begin
              load       = 1'b1;
              claim      = 1'b1;
              claim_bank = ~rd_bank;
              rd_idx_sel = IDX_W'(1);
            end
          end
        end else if (hs) begin
          load = 1'b1;
          if (rd_idx == LAST_IDX) begin
            rd_bank_sel = ~rd_bank;
            rd_idx_sel  = '0;
          end else begin
            rd_idx_sel = rd_idx + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // p2: output register, held while the FFT stalls
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      rd_bank     <= 1'b0;
      rd_idx      <= '0;
      vld_p2      <= 1'b0;
      last_p2     <= 1'b0;
      out_real_p2 <= '0;
    end else begin
      if (release_bank) rd_bank <= ~rd_bank;
      if (load) begin
        rd_idx      <= claim ? IDX_W'(1) : rd_idx + 1'b1;
        out_real_p2 <= rd_real_p1;
        vld_p2      <= 1'b1;
        last_p2     <= !claim && (rd_idx == LAST_IDX);
      end else if (hs) begin
        vld_p2  <= 1'b0;
        last_p2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      if (frame_done)   bank_st[tgt_bank]   <= BANK_FULL;
      if (claim)        bank_st[claim_bank] <= BANK_DRAINING;
      if (release_bank) bank_st[rd_bank]    <= BANK_EMPTY;
    end
  end

  assign fft.fft_tdata  = {{(WIDTH-HALF_W){1'b0}}, out_real_p2};
  assign fft.fft_tvalid = vld_p2;
  assign fft.fft_tlast  = last_p2;
endmodule

// File: tb/tb_mic_frame_scheduler.sv
// Randomized bench for mic_frame_scheduler against a frame-level queue model.
module tb_mic_frame_scheduler;
  localparam int WIDTH     = 32;
  localparam int FRAME_LEN = 8;
  localparam int DECIM     = 4;

  logic        adc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] mic_sample = '0;
  logic        tready_drv = 1'b0;
  logic        overrun;
  logic [15:0] samples_dropped;
  logic        capturing;

  mic_frame_scheduler_if #(.WIDTH(WIDTH)) bus ();
  assign bus.fft_tready = tready_drv;

  mic_frame_scheduler #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .DECIM(DECIM)) dut (
    .adc_clk         (adc_clk),
    .reset           (reset),
    .enable          (enable),
    .mic_sample      (mic_sample),
    .fft             (bus),
    .overrun         (overrun),
    .samples_dropped (samples_dropped),
    .capturing       (capturing)
  );

  always #5 adc_clk = ~adc_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: completed frames queue in fill order; a frame occupies a bank
  // from its first sample until the edge its last word is accepted.
  int          edge_n = 0;
  int          run = 0;
  int          widx = 0;
  logic [15:0] part[$];
  logic [15:0] pend_words[$];
  int          pend_done[$];
  logic        m_over = 1'b0;
  logic [15:0] m_drop = '0;
  int          tl_edges[$];

  function automatic logic [15:0] exp_real(input logic [11:0] s);
`ifdef MIC_DC_REMOVE_EN
    int v;
    v = (int'(s) - 2048) >>> 5;
    return v[15:0];
`else
    return 16'(s >> 5);
`endif
  endfunction

  task automatic step(input logic en, input logic [11:0] smp, input logic rdy, input logic rst);
    logic hs;
    logic stb;
    logic vld_exp;
    @(negedge adc_clk);
    enable     = en;
    mic_sample = smp;
    tready_drv = rdy;
    reset      = rst;
    hs = bus.fft_tvalid && rdy;
    edge_n++;
    if (rst) begin
      run = 0; widx = 0; m_over = 1'b0; m_drop = '0;
      part.delete(); pend_words.delete(); pend_done.delete();
    end else begin
      stb = 1'b0;
      if (en) begin
        run++;
        stb = (run % DECIM) == 0;
      end else begin
        run = 0;
        part.delete();
      end
      if (stb) begin
        if (part.size() > 0 || pend_done.size() < 2) begin
          part.push_back(exp_real(smp));
          if (part.size() == FRAME_LEN) begin
            foreach (part[i]) pend_words.push_back(part[i]);
            pend_done.push_back(edge_n);
            part.delete();
          end
        end else begin
          m_over = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
      if (hs && pend_done.size() > 0) begin
        widx++;
        if (widx == FRAME_LEN) begin
          tl_edges.push_back(edge_n);
          for (int i = 0; i < FRAME_LEN; i++) void'(pend_words.pop_front());
          void'(pend_done.pop_front());
          widx = 0;
        end
      end
    end
    @(posedge adc_clk);
    #1;
    vld_exp = (pend_done.size() > 0) && (pend_done[0] < edge_n);
    check("tvalid", 32'(bus.fft_tvalid), 32'(vld_exp));
    if (vld_exp) begin
      check("tdata", bus.fft_tdata, {16'h0, pend_words[widx]});
      check("tlast", 32'(bus.fft_tlast), 32'(widx == FRAME_LEN - 1));
    end
    if (rst) begin
      check("rst_tdata", bus.fft_tdata, 32'h0);
      check("rst_tlast", 32'(bus.fft_tlast), 32'h0);
    end
    check("overrun", 32'(overrun), 32'(m_over));
    check("dropped", 32'(samples_dropped), 32'(m_drop));
    check("capturing", 32'(capturing), 32'(part.size() > 0));
  endtask

  initial begin
    int stall_left;
    logic r;
    stall_left = 0;
    repeat (3) step(1'b0, 12'd0, 1'b0, 1'b1);

    // ramp 0,32,64,... with ready high
    for (int k = 0; k < DECIM * FRAME_LEN * 3; k++)
      step(1'b1, 12'((k / DECIM) * 32), 1'b1, 1'b0);

    // long FFT stall forces both banks full and drops
    for (int k = 0; k < 20; k++)  step(1'b1, 12'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < 120; k++) step(1'b1, 12'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) step(1'b1, 12'($urandom), 1'b1, 1'b0);

    // enable drops after three samples of a frame
    repeat (2) step(1'b0, 12'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3 * DECIM; k++) step(1'b1, 12'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < 10; k++)        step(1'b0, 12'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < 80; k++)        step(1'b1, 12'($urandom), 1'b1, 1'b0);

    // reset while a frame is streaming
    for (int k = 0; k < 60; k++) step(1'b1, 12'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)  step(1'b1, 12'($urandom), 1'b1, 1'b0);
    step(1'b1, 12'($urandom), 1'b1, 1'b1);
    for (int k = 0; k < 5; k++)  step(1'b1, 12'($urandom), 1'b1, 1'b0);

    // steady ready over many frames: tlast spacing and no overrun
    repeat (2) step(1'b0, 12'd0, 1'b1, 1'b1);
    tl_edges.delete();
    for (int k = 0; k < 11 * FRAME_LEN * DECIM + 40; k++) step(1'b1, 12'($urandom), 1'b1, 1'b0);
    check("tlast_count", 32'(tl_edges.size() >= 10), 32'h1);
    for (int i = 1; i < tl_edges.size(); i++)
      check("tlast_gap", 32'(tl_edges[i] - tl_edges[i-1]), 32'(FRAME_LEN * DECIM));
    check("overrun_steady", 32'(overrun), 32'h0);

    // random traffic with bursty stalls, rare enable drops and resets
    for (int k = 0; k < 2000; k++) begin
      if (stall_left > 0) begin
        stall_left--;
        r = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        stall_left = $urandom_range(10, 90);
        r = 1'b0;
      end else begin
        r = ($urandom_range(0, 3) != 0);
      end
      step(($urandom_range(0, 199) != 0), 12'($urandom), r, ($urandom_range(0, 999) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
